// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60 defaults) and total-length helpers.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FRONT  = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BACK   = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FRONT  = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BACK   = 33;
  localparam int unsigned VGA_CLK_DIV  = 1;
  localparam int unsigned VGA_CW       = 12;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with registered sync decode.
// next_count/next_active expose the post-edge values so the parent can register aligned outputs.
module vga_axis_counter #(
  parameter int unsigned ACTIVE   = 640,
  parameter int unsigned FRONT    = 16,
  parameter int unsigned SYNC_LEN = 96,
  parameter int unsigned BACK     = 48,
  parameter bit          POL      = 1'b0,
  parameter int unsigned CW       = 12
) (
  input  logic          board_clock,
  input  logic          reset,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic [CW-1:0] next_count,
  output logic          next_active,
  output logic          at_last,
  output logic          sync
);

  localparam int unsigned TOTAL = ACTIVE + FRONT + SYNC_LEN + BACK;
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FRONT);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FRONT + SYNC_LEN);

  logic next_sync;

  always_comb begin
    at_last     = (count == LAST);
    next_count  = count;
    if (step) begin
      next_count = at_last ? '0 : count + CW'(1);
    end
    next_active = (next_count < ACT_END);
    next_sync   = ((next_count >= SYNC_START) && (next_count < SYNC_END)) ? POL : ~POL;
  end

  // Reset parks the axis on its last position so the first step lands on 0.
  always_ff @(posedge board_clock or posedge reset) begin
    if (reset) begin
      count <= LAST;
      sync  <= ~POL;
    end else begin
      count <= next_count;
      sync  <= next_sync;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-clock divider driving horizontal and vertical axes,
// with every output registered on the same edge as the counters.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
  parameter int unsigned CW        = VGA_CW
) (
  input  logic          board_clock,
  input  logic          reset,
  input  logic          enable,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam longint unsigned CNT_RANGE = 64'd1 << CW;

  if (H_ACTIVE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 ||
      CLK_DIV == 0 || CW == 0) begin : g_bad_param
    $error("vga_timing_gen: timing parameters and CLK_DIV must be at least 1");
  end
  if (64'(H_TOTAL) > CNT_RANGE || 64'(V_TOTAL) > CNT_RANGE) begin : g_bad_width
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic          pix_tick;
  logic          h_step, v_step;
  logic          h_last, v_last;
  logic [CW-1:0] h_next, v_next;
  logic          h_next_active, v_next_active;
  logic          de_d;

  assign pix_tick = (div_q == DIV_LAST);
  assign h_step   = enable & pix_tick;
  assign v_step   = h_step & h_last;
  assign de_d     = h_next_active & v_next_active;

  always_ff @(posedge board_clock or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (enable) begin
      div_q <= pix_tick ? '0 : div_q + DW'(1);
    end
  end

  vga_axis_counter #(
    .ACTIVE   (H_ACTIVE),
    .FRONT    (H_FRONT),
    .SYNC_LEN (H_SYNC),
    .BACK     (H_BACK),
    .POL      (HSYNC_POL),
    .CW       (CW)
  ) u_h_axis (
    .board_clock (board_clock),
    .reset       (reset),
    .step        (h_step),
    .count       (h_count),
    .next_count  (h_next),
    .next_active (h_next_active),
    .at_last     (h_last),
    .sync        (hsync)
  );

  vga_axis_counter #(
    .ACTIVE   (V_ACTIVE),
    .FRONT    (V_FRONT),
    .SYNC_LEN (V_SYNC),
    .BACK     (V_BACK),
    .POL      (VSYNC_POL),
    .CW       (CW)
  ) u_v_axis (
    .board_clock (board_clock),
    .reset       (reset),
    .step        (v_step),
    .count       (v_count),
    .next_count  (v_next),
    .next_active (v_next_active),
    .at_last     (v_last),
    .sync        (vsync)
  );

  // Strobes are only set on a stepping edge, so they clear on the following board_clock.
  always_ff @(posedge board_clock or posedge reset) begin
    if (reset) begin
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      de          <= de_d;
      x           <= de_d ? h_next : '0;
      y           <= de_d ? v_next : '0;
      line_start  <= h_step & h_last;
      frame_start <= v_step & v_last;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four configurations checked every cycle against an arithmetic
// raster model (position derived from the number of pixel ticks since reset).
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hsw, hb, va, vf, vsw, vb;
    bit hp, vp;
    int div;
  } cfg_t;

  typedef struct packed {
    logic        hs, vs, de;
    logic [11:0] x, y, h, v;
    logic        ls, fs;
  } obs_t;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst, en;
  always #5 clk = ~clk;

  logic        hs_o[N], vs_o[N], de_o[N], ls_o[N], fs_o[N];
  logic [11:0] x_o[N], y_o[N], h_o[N], v_o[N];

  vga_timing_gen u_dut0 (
    .board_clock (clk), .reset (rst), .enable (en),
    .hsync (hs_o[0]), .vsync (vs_o[0]), .de (de_o[0]), .x (x_o[0]), .y (y_o[0]),
    .h_count (h_o[0]), .v_count (v_o[0]), .line_start (ls_o[0]), .frame_start (fs_o[0])
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
  ) u_dut1 (
    .board_clock (clk), .reset (rst), .enable (en),
    .hsync (hs_o[1]), .vsync (vs_o[1]), .de (de_o[1]), .x (x_o[1]), .y (y_o[1]),
    .h_count (h_o[1]), .v_count (v_o[1]), .line_start (ls_o[1]), .frame_start (fs_o[1])
  );

  vga_timing_gen #(.CLK_DIV (4)) u_dut2 (
    .board_clock (clk), .reset (rst), .enable (en),
    .hsync (hs_o[2]), .vsync (vs_o[2]), .de (de_o[2]), .x (x_o[2]), .y (y_o[2]),
    .h_count (h_o[2]), .v_count (v_o[2]), .line_start (ls_o[2]), .frame_start (fs_o[2])
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
    .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b0), .CLK_DIV (3)
  ) u_dut3 (
    .board_clock (clk), .reset (rst), .enable (en),
    .hsync (hs_o[3]), .vsync (vs_o[3]), .de (de_o[3]), .x (x_o[3]), .y (y_o[3]),
    .h_count (h_o[3]), .v_count (v_o[3]), .line_start (ls_o[3]), .frame_start (fs_o[3])
  );

  cfg_t cfg[N];
  int   checks = 0;
  int   errors = 0;

  // Model state: enabled edges since reset, and whether the latest edge produced a pixel tick.
  int   e_cnt[N];
  bit   ticked[N];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        e_cnt[i]  <= 0;
        ticked[i] <= 1'b0;
      end else begin
        ticked[i] <= en && (((e_cnt[i] + 1) % cfg[i].div) == 0);
        e_cnt[i]  <= e_cnt[i] + (en ? 1 : 0);
      end
    end
  end

  function automatic obs_t model(cfg_t c, int e, bit t);
    obs_t o;
    int ht, vt, n, l, h, v;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    n  = e / c.div;
    l  = (n + ht * vt - 1) % (ht * vt);
    h  = l % ht;
    v  = l / ht;
    o.h  = 12'(h);
    o.v  = 12'(v);
    o.de = (h < c.ha) && (v < c.va);
    o.x  = o.de ? 12'(h) : 12'd0;
    o.y  = o.de ? 12'(v) : 12'd0;
    o.hs = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw) ? c.hp : !c.hp;
    o.vs = (v >= c.va + c.vf && v < c.va + c.vf + c.vsw) ? c.vp : !c.vp;
    o.ls = t && (h == 0);
    o.fs = t && (l == 0);
    return o;
  endfunction

  function automatic obs_t obs(int i);
    obs_t o;
    o.hs = hs_o[i]; o.vs = vs_o[i]; o.de = de_o[i];
    o.x  = x_o[i];  o.y  = y_o[i];  o.h  = h_o[i];  o.v = v_o[i];
    o.ls = ls_o[i]; o.fs = fs_o[i];
    return o;
  endfunction

  task automatic cmp(input string name, input obs_t a, input obs_t w);
    checks++;
    if (a !== w) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s t=%0t got h=%0d v=%0d hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b want h=%0d v=%0d hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                 name, $time, a.h, a.v, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs,
                 w.h, w.v, w.hs, w.vs, w.de, w.x, w.y, w.ls, w.fs);
    end
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) cmp($sformatf("model_dut%0d", i), obs(i), model(cfg[i], e_cnt[i], ticked[i]));
  end

  // Strobe timestamps during the uninterrupted run; also track x/y extremes of the small raster.
  bit phase = 1'b0;
  int cyc = 0;
  int t_ls[N][2];
  int t_fs[N][2];
  int n_ls[N];
  int n_fs[N];
  int xmax = 0, ymax = 0;

  always @(negedge clk) begin
    if (phase) begin
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (ls_o[i] && n_ls[i] < 2) begin t_ls[i][n_ls[i]] = cyc; n_ls[i]++; end
        if (fs_o[i] && n_fs[i] < 2) begin t_fs[i][n_fs[i]] = cyc; n_fs[i]++; end
      end
    end
    if (!rst) begin
      if (int'(x_o[1]) > xmax) xmax = int'(x_o[1]);
      if (int'(y_o[1]) > ymax) ymax = int'(y_o[1]);
    end
  end

  initial begin
    obs_t o;
    int   de_cnt;
    bit   found;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1};
    cfg[1] = '{8, 2, 3, 2, 4, 1, 1, 1, 1'b1, 1'b1, 1};
    cfg[2] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 4};
    cfg[3] = '{8, 2, 3, 2, 4, 1, 1, 1, 1'b1, 1'b0, 3};
    rst = 1'b1;
    en  = 1'b0;

    // Pin the model against hand-derived timing points.
    o = model(cfg[0], 656, 1'b0); lit("pin_h655_hs", o.hs, 1);
    o = model(cfg[0], 657, 1'b0); lit("pin_h656", o.h, 656); lit("pin_h656_hs", o.hs, 0);
    o = model(cfg[0], 752, 1'b0); lit("pin_h751_hs", o.hs, 0);
    o = model(cfg[0], 753, 1'b0); lit("pin_h752_hs", o.hs, 1);
    o = model(cfg[0], 489 * 800 + 1, 1'b0); lit("pin_v489_vs", o.vs, 1);
    o = model(cfg[0], 490 * 800 + 1, 1'b0); lit("pin_v490_vs", o.vs, 0);
    o = model(cfg[0], 420000, 1'b0); lit("pin_wrap_h", o.h, 799); lit("pin_wrap_v", o.v, 524);
    o = model(cfg[0], 420001, 1'b1); lit("pin_frame_fs", o.fs, 1);
    o = model(cfg[1], 11, 1'b0); lit("pin_small_hs", o.hs, 1);
    de_cnt = 0;
    for (int e = 1; e <= 420000; e++) begin
      o = model(cfg[0], e, 1'b0);
      if (o.de) de_cnt++;
    end
    lit("pin_de_per_frame", de_cnt, 307200);

    repeat (3) @(posedge clk);
    @(negedge clk);
    lit("reset_h", h_o[0], 799);   lit("reset_v", v_o[0], 524);
    lit("reset_hs", hs_o[0], 1);   lit("reset_de", de_o[0], 0);
    lit("reset_small_h", h_o[1], 14); lit("reset_small_hs", hs_o[1], 0);

    #2 rst = 1'b0;
    en    = 1'b1;
    phase = 1'b1;
    @(negedge clk);
    lit("first_h", h_o[0], 0);  lit("first_v", v_o[0], 0);
    lit("first_de", de_o[0], 1); lit("first_ls", ls_o[0], 1); lit("first_fs", fs_o[0], 1);
    lit("first_small_fs", fs_o[1], 1);

    found = 1'b0;
    for (int k = 0; k < 6000 && !found; k++) begin
      @(negedge clk);
      if (h_o[0] == 12'd300 && v_o[0] == 12'd5) found = 1'b1;
    end
    lit("reach_h300_v5", found, 1);
    phase = 1'b0;
    lit("line_period_div1", t_ls[0][1] - t_ls[0][0], 800);
    lit("line_period_div4", t_ls[2][1] - t_ls[2][0], 3200);
    lit("frame_period_small", t_fs[1][1] - t_fs[1][0], 105);
    lit("frame_period_small_div3", t_fs[3][1] - t_fs[3][0], 315);

    en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      lit("hold_h", h_o[0], 300); lit("hold_v", v_o[0], 5);
    end
    en = 1'b1;
    @(negedge clk);
    lit("resume_h", h_o[0], 301);

    repeat (6000) begin
      @(negedge clk);
      en = ($urandom_range(0, 7) != 0);
    end
    lit("small_x_max", xmax, 7);
    lit("small_y_max", ymax, 3);

    en = 1'b1;
    repeat (37) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) cmp($sformatf("async_reset_dut%0d", i), obs(i), model(cfg[i], 0, 1'b0));
    lit("async_reset_h", h_o[0], 799);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    lit("rerelease_h", h_o[0], 0); lit("rerelease_v", v_o[0], 0);
    lit("rerelease_fs", fs_o[0], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vsync width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 Parameter HSYNC_POL, default 0, active level of hsync.
REQ-010 Parameter VSYNC_POL, default 0, active level of vsync.
REQ-011 Parameter CLK_DIV, default 1, board_clock cycles per pixel (>=1).
REQ-012 Parameter CW, default 12, counter and coordinate width.
REQ-013 board_clock  in  1  sole clock; all state on rising edge.
REQ-014 reset  in  1  asynchronous, active-high reset.
REQ-015 enable  in  1  run/hold control.
REQ-016 hsync  out  1  horizontal sync, HSYNC_POL when active.
REQ-017 vsync  out  1  vertical sync, VSYNC_POL when active.
REQ-018 de  out  1  data enable, high in visible region.
REQ-019 x, y  out  CW each  visible pixel coordinate.
REQ-020 h_count, v_count  out  CW each  raw timing counters.
REQ-021 line_start, frame_start  out  1 each  one-board_clock pulses.

Function
REQ-022 H_TOTAL = sum of H params, V_TOTAL = sum of V params; region order active, front, sync, back.
REQ-023 pix_tick: divider counts 0..CLK_DIV-1, tick in the cycle divider = CLK_DIV-1; CLK_DIV=1 ticks every cycle.
REQ-024 On pix_tick with enable high: h_count increments; at H_TOTAL-1 wraps to 0 and v_count increments; v_count wraps from V_TOTAL-1 to 0.
REQ-025 enable low: divider, counters and all outputs hold; strobes forced 0; resume continues from held values.
REQ-026 All outputs registered, updated on the same edge as h_count/v_count and decoded from the new counter values (zero skew between counts and decoded signals).
REQ-027 hsync active iff H_ACTIVE+H_FRONT <= h_count < H_ACTIVE+H_FRONT+H_SYNC; vsync likewise on v_count with V params.
REQ-028 de = (h_count < H_ACTIVE) and (v_count < V_ACTIVE).
REQ-029 x = h_count and y = v_count when de high, otherwise both 0.
REQ-030 line_start high for exactly one board_clock on the edge h_count becomes 0; frame_start when (h,v) becomes (0,0); both regardless of CLK_DIV.
REQ-031 Any timing param < 1, CLK_DIV < 1, or H_TOTAL/V_TOTAL exceeding 2^CW SHALL fail elaboration.

Reset
REQ-032 reset asserts immediately (async): divider 0, h_count=H_TOTAL-1, v_count=V_TOTAL-1, hsync/vsync inactive, de=0, x=y=0, strobes 0.
REQ-033 First pix_tick after release yields (0,0) with de=1, line_start=1, frame_start=1.
REQ-034 reset mid-frame discards position; no partial-frame recovery.

Structure
REQ-035 Package vga_pkg holds default 640x480@60 timing constants and H_TOTAL/V_TOTAL helper functions.
REQ-036 One sub-module vga_axis_counter (count, wrap, sync/active decode) instanced twice, horizontal and vertical.

Verification
REQ-037 Defaults, enable=1, release reset -> next edge h=0,v=0, frame_start=1; hsync low exactly h 656..751; line_start period 800 cycles.
REQ-038 Defaults, full frame -> vsync low only v 490..491; frame_start period 420000 cycles; de high 307200 cycles per frame.
REQ-039 CLK_DIV=4 -> h_count steps every 4 cycles; line_start/frame_start 1 cycle wide; line period 3200 cycles.
REQ-040 enable low for 10 cycles at h=300,v=5 -> all outputs constant; first tick after re-enable gives h=301.
REQ-041 H 8/2/3/2, V 4/1/1/1, HSYNC_POL=VSYNC_POL=1 -> hsync high h 10..12, vsync high v 5, totals 15 and 7, x max 7, y max 3.
REQ-042 reset pulse asynchronous (between edges) at v=200 -> outputs at reset values before next edge; after release first tick gives (0,0) with frame_start.
